// File: rtl/if_fetch.sv
// Instruction fetch stage: issues in-order reads for the PC presented by the
// PC register, pairs each response with its address in a small FIFO for
// decode, drops stale responses after a jump, and holds the PC whenever an
// address is not accepted by memory.
module if_fetch #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        jump_en,
  output logic        pc_hold_o,
  output logic        req_valid_o,
  input  logic        req_ready_i,
  output logic [31:0] req_addr_o,
  input  logic        rsp_valid_i,
  input  logic [31:0] rsp_data_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CSW = CW + 1;

  logic [CW-1:0] out_cnt_q,  out_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

  logic [AW-1:0] awr_ptr_q, awr_ptr_d, ard_ptr_q, ard_ptr_d;
  logic [AW-1:0] iwr_ptr_q, iwr_ptr_d, ird_ptr_q, ird_ptr_d;

  logic [31:0] addr_mem_q  [FIFO_DEPTH];
  logic [31:0] inst_mem_q  [FIFO_DEPTH];
  logic [31:0] iaddr_mem_q [FIFO_DEPTH];

  logic           fire, pop, rsp_take, rsp_drop, push;
  logic [CSW-1:0] credit_used;

  // Request side: credits cover outstanding plus buffered fetches, so a
  // response always finds room in the instruction FIFO.
  assign pop         = inst_valid_o && inst_ready_i && !jump_en;
  assign credit_used = {1'b0, out_cnt_q} + {1'b0, fifo_cnt_q} - CSW'(pop);
  assign req_valid_o = rst && !jump_en && (credit_used < CSW'(FIFO_DEPTH));
  assign fire        = req_valid_o && req_ready_i;
  assign pc_hold_o   = !fire;
  assign req_addr_o  = pc_i & ~32'h3;

  // Response side: responses with nothing outstanding are ignored; a flush
  // discards the response arriving in the same cycle.
  assign rsp_take = rsp_valid_i && (out_cnt_q != '0);
  assign rsp_drop = rsp_take && ((drop_cnt_q != '0) || jump_en);
  assign push     = rsp_take && !rsp_drop;

  assign inst_valid_o = (fifo_cnt_q != '0);
  assign inst_o       = inst_valid_o ? inst_mem_q[ird_ptr_q]  : NOP_INST;
  assign inst_addr_o  = inst_valid_o ? iaddr_mem_q[ird_ptr_q] : 32'h0;

  // Next-state for counters and pointers, including flush handling.
  always_comb begin
    out_cnt_d  = out_cnt_q + CW'(fire) - CW'(rsp_take);
    drop_cnt_d = drop_cnt_q - CW'(rsp_take && (drop_cnt_q != '0));
    fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    awr_ptr_d  = awr_ptr_q + AW'(fire);
    ard_ptr_d  = ard_ptr_q + AW'(rsp_take);
    iwr_ptr_d  = iwr_ptr_q + AW'(push);
    ird_ptr_d  = ird_ptr_q + AW'(pop);
    if (jump_en) begin
      // Everything still in flight after this cycle's response is stale.
      drop_cnt_d = out_cnt_q - CW'(rsp_take);
      fifo_cnt_d = '0;
      iwr_ptr_d  = '0;
      ird_ptr_d  = '0;
    end
  end

  // Counter and pointer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      fifo_cnt_q <= '0;
      awr_ptr_q  <= '0;
      ard_ptr_q  <= '0;
      iwr_ptr_q  <= '0;
      ird_ptr_q  <= '0;
    end else begin
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      awr_ptr_q  <= awr_ptr_d;
      ard_ptr_q  <= ard_ptr_d;
      iwr_ptr_q  <= iwr_ptr_d;
      ird_ptr_q  <= ird_ptr_d;
    end
  end

  // FIFO storage; contents are qualified by the counters so need no reset.
  always_ff @(posedge clk) begin
    if (rst && fire) begin
      addr_mem_q[awr_ptr_q] <= req_addr_o;
    end
    if (rst && push) begin
      inst_mem_q[iwr_ptr_q]  <= rsp_data_i;
      iaddr_mem_q[iwr_ptr_q] <= addr_mem_q[ard_ptr_q];
    end
  end

endmodule
